fft_reorder_buf: RTL

- Ping-pong reorder buffer at the FFT output for the 240-point mixed-radix path.
- Accepts one 240-sample frame in natural arrival order.
- Replays the frame in mixed-radix digit-reversed order to the downstream stage.
- Generates reversal addresses internally with digit counters; no lookup table.
- Two banks, so one frame can fill while the other drains.

---
 rtl/fft_reorder_pkg.sv | 32 +++
 rtl/digrev_addr_gen.sv | 82 ++++++++
 rtl/fft_reorder_buf.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/fft_reorder_pkg.sv
// rtl/fft_reorder_pkg.sv - shared constants and types for the 240-point digit-reversal reorder buffer
package fft_reorder_pkg;

  // Radix set of the 240-point mixed-radix FFT: n = d0 + 4*d1 + 16*d2 + 48*d3
  localparam int R0 = 4;
  localparam int R1 = 4;
  localparam int R2 = 3;
  localparam int R3 = 5;

  // Digit weights of the reversed address: addr = 60*d0 + 15*d1 + 5*d2 + d3
  localparam int W0 = 60;
  localparam int W1 = 15;
  localparam int W2 = 5;
  localparam int W3 = 1;

  localparam int FRAME_LEN = R0 * R1 * R2 * R3;

  // Address deltas applied when a carry ripples up to digit k: every lower
  // digit returns from its maximum to zero, then digit k advances once.
  localparam int DELTA0 = W0;
  localparam int DELTA1 = W1 - (R0 - 1) * W0;
  localparam int DELTA2 = W2 - (R1 - 1) * W1 - (R0 - 1) * W0;
  localparam int DELTA3 = W3 - (R2 - 1) * W2 - (R1 - 1) * W1 - (R0 - 1) * W0;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

endpackage

// File: rtl/digrev_addr_gen.sv
// rtl/digrev_addr_gen.sv - mixed-radix (4,4,3,5) digit-reversed address counter
// Ports:
//   clk   clock
//   rst   synchronous active-high reset, returns to n=0 / addr=0
//   step  advance to the next index n
//   addr  reversed address of the current index n
//   last  current index is n=239; the next step wraps to 0
module digrev_addr_gen
  import fft_reorder_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          step,
  output logic [AW-1:0] addr,
  output logic          last
);

  // Negative deltas wrap modulo 2^AW, so a single adder covers every carry case.
  localparam logic [AW-1:0] INC0 = AW'(DELTA0);
  localparam logic [AW-1:0] INC1 = AW'(DELTA1);
  localparam logic [AW-1:0] INC2 = AW'(DELTA2);
  localparam logic [AW-1:0] INC3 = AW'(DELTA3);

  logic [1:0]    d0;
  logic [1:0]    d1;
  logic [1:0]    d2;
  logic [2:0]    d3;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] addr_n;
  logic          wrap0;
  logic          wrap1;
  logic          wrap2;
  logic          wrap3;

  assign wrap0 = (d0 == 2'(R0 - 1));
  assign wrap1 = (d1 == 2'(R1 - 1));
  assign wrap2 = (d2 == 2'(R2 - 1));
  assign wrap3 = (d3 == 3'(R3 - 1));

  assign last = wrap0 & wrap1 & wrap2 & wrap3;
  assign addr = addr_q;

  always_comb begin
    addr_n = addr_q;
    if (!wrap0) begin
      addr_n = addr_q + INC0;
    end else if (!wrap1) begin
      addr_n = addr_q + INC1;
    end else if (!wrap2) begin
      addr_n = addr_q + INC2;
    end else if (!wrap3) begin
      addr_n = addr_q + INC3;
    end else begin
      addr_n = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d0     <= '0;
      d1     <= '0;
      d2     <= '0;
      d3     <= '0;
      addr_q <= '0;
    end else if (step) begin
      d0     <= wrap0 ? 2'd0 : d0 + 2'd1;
      if (wrap0) begin
        d1 <= wrap1 ? 2'd0 : d1 + 2'd1;
      end
      if (wrap0 && wrap1) begin
        d2 <= wrap2 ? 2'd0 : d2 + 2'd1;
      end
      if (wrap0 && wrap1 && wrap2) begin
        d3 <= wrap3 ? 3'd0 : d3 + 3'd1;
      end
      addr_q <= addr_n;
    end
  end

endmodule

// File: rtl/fft_reorder_buf.sv
// rtl/fft_reorder_buf.sv - ping-pong reorder buffer, natural order in, digit-reversed order out
// Ports:
//   clk, rst                                        clock, synchronous active-high reset
//   in_valid, in_data, in_ready                     natural-order sample stream
//   out_valid, out_data, out_sop, out_eop, out_ready  digit-reversed sample stream
module fft_reorder_buf
  import fft_reorder_pkg::*;
#(
  parameter int DW = 32,
  parameter int N  = FRAME_LEN,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_sop,
  output logic          out_eop,
  input  logic          out_ready
);

  bank_state_t   bank_st [2];
  logic          wbank;
  logic          rbank;
  logic [AW-1:0] w;
  logic          wr_en;

  logic [DW-1:0] mem0 [0:N-1];
  logic [DW-1:0] mem1 [0:N-1];

  logic [AW-1:0] raddr;
  logic          rd_last;
  logic          rd_avail;
  logic          rd_issue;
  logic          space_ok;
  logic [2:0]    occ;

  logic [DW-1:0] rd0_q;
  logic [DW-1:0] rd1_q;
  logic          rd_pend;
  logic          rd_bank_q;
  logic          rd_sop_q;
  logic          rd_eop_q;
  logic [DW-1:0] rd_data;

  logic          ov_q;
  logic [DW-1:0] od_q;
  logic          os_q;
  logic          oe_q;
  logic [DW-1:0] skd [2];
  logic          sks [2];
  logic          ske [2];
  logic [1:0]    sk_cnt;

  logic          ov_n;
  logic [DW-1:0] od_n;
  logic          os_n;
  logic          oe_n;
  logic [DW-1:0] skd_n [2];
  logic          sks_n [2];
  logic          ske_n [2];
  logic [1:0]    cnt_n;

  logic          pop;
  logic          take_out;

  // ---------------- write side ----------------
  assign in_ready = (bank_st[wbank] == EMPTY) || (bank_st[wbank] == FILLING);
  assign wr_en    = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      w     <= '0;
      wbank <= 1'b0;
    end else if (wr_en) begin
      if (w == AW'(N - 1)) begin
        w     <= '0;
        wbank <= ~wbank;
      end else begin
        w <= w + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !wbank) mem0[w] <= in_data;
    if (wr_en && wbank)  mem1[w] <= in_data;
  end

  // ---------------- bank states ----------------
  // A bank is written only while EMPTY/FILLING and read only while
  // FULL/DRAINING, so the two sides never update the same bank together.
  // A bank is released once its last word has left the RAM; the remaining
  // words of that frame sit in the output pipeline, which keeps the input
  // running at full rate in steady state.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (rst) begin
        bank_st[b] <= EMPTY;
      end else if (wr_en && (wbank == 1'(b))) begin
        bank_st[b] <= (w == AW'(N - 1)) ? FULL : FILLING;
      end else if (rd_issue && (rbank == 1'(b))) begin
        bank_st[b] <= rd_last ? EMPTY : DRAINING;
      end
    end
  end

  // ---------------- read side ----------------
  digrev_addr_gen #(.AW(AW)) u_addr_gen (
    .clk  (clk),
    .rst  (rst),
    .step (rd_issue),
    .addr (raddr),
    .last (rd_last)
  );

  assign rd_avail = (bank_st[rbank] == FULL) || (bank_st[rbank] == DRAINING);

  // Output register plus two skid entries hold three words; a read is
  // issued only if the word it returns next cycle is guaranteed a slot.
  assign pop      = ov_q & out_ready;
  assign occ      = 3'(ov_q) + 3'(sk_cnt) + 3'(rd_pend);
  assign space_ok = (occ - 3'(pop)) <= 3'd2;
  assign rd_issue = rd_avail & space_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      rbank <= 1'b0;
    end else if (rd_issue && rd_last) begin
      rbank <= ~rbank;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_issue) begin
      rd0_q <= mem0[raddr];
      rd1_q <= mem1[raddr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend   <= 1'b0;
      rd_bank_q <= 1'b0;
      rd_sop_q  <= 1'b0;
      rd_eop_q  <= 1'b0;
    end else begin
      rd_pend <= rd_issue;
      if (rd_issue) begin
        rd_bank_q <= rbank;
        rd_sop_q  <= (raddr == '0);
        rd_eop_q  <= rd_last;
      end
    end
  end

  assign rd_data = rd_bank_q ? rd1_q : rd0_q;

  // ---------------- output register and skid buffer ----------------
  assign take_out = ~ov_q | pop;

  always_comb begin
    ov_n  = ov_q;
    od_n  = od_q;
    os_n  = os_q;
    oe_n  = oe_q;
    skd_n = skd;
    sks_n = sks;
    ske_n = ske;
    cnt_n = sk_cnt;
    if (take_out) begin
      if (sk_cnt != 2'd0) begin
        ov_n     = 1'b1;
        od_n     = skd[0];
        os_n     = sks[0];
        oe_n     = ske[0];
        skd_n[0] = skd[1];
        sks_n[0] = sks[1];
        ske_n[0] = ske[1];
        cnt_n    = sk_cnt - 2'd1;
      end else if (rd_pend) begin
        ov_n = 1'b1;
        od_n = rd_data;
        os_n = rd_sop_q;
        oe_n = rd_eop_q;
      end else begin
        ov_n = 1'b0;
      end
    end
    // Returning RAM word goes behind any queued words unless it went
    // straight into the output register above.
    if (rd_pend && !(take_out && (sk_cnt == 2'd0))) begin
      skd_n[cnt_n[0]] = rd_data;
      sks_n[cnt_n[0]] = rd_sop_q;
      ske_n[cnt_n[0]] = rd_eop_q;
      cnt_n           = cnt_n + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ov_q   <= 1'b0;
      od_q   <= '0;
      os_q   <= 1'b0;
      oe_q   <= 1'b0;
      sk_cnt <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        skd[i] <= '0;
        sks[i] <= 1'b0;
        ske[i] <= 1'b0;
      end
    end else begin
      ov_q   <= ov_n;
      od_q   <= od_n;
      os_q   <= os_n;
      oe_q   <= oe_n;
      sk_cnt <= cnt_n;
      skd    <= skd_n;
      sks    <= sks_n;
      ske    <= ske_n;
    end
  end

  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_sop   = ov_q & os_q;
  assign out_eop   = ov_q & oe_q;

endmodule
